// File: rtl/challenge_obfuscator_param.sv
// Time-multiplexed challenge obfuscator: one GW-bit group per clock through a shared
// transform (bypass / rotate / chain-XOR / LFSR mask), with valid/ready on both sides.
module challenge_obfuscator_param #(
    parameter int                NGROUP    = 10,
    parameter int                GW        = 3,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1
) (
    input  logic                   i_clk,
    input  logic                   i_clear,
    input  logic                   i_c_valid,
    output logic                   o_c_ready,
    input  logic [NGROUP*GW-1:0]   i_c_in,
    input  logic [1:0]             i_mode,
    input  logic                   i_seed_load,
    input  logic [LFSR_W-1:0]      i_seed,
    output logic                   o_cbar_valid,
    input  logic                   i_cbar_ready,
    output logic [NGROUP*GW-1:0]   o_cbar_out,
    output logic                   o_busy
);

    localparam int CW     = NGROUP * GW;
    localparam int GIDX_W = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_BYPASS = 2'b00;
    localparam logic [1:0] M_ROTL   = 2'b01;
    localparam logic [1:0] M_CHAIN  = 2'b10;
    localparam logic [1:0] M_MASK   = 2'b11;

    logic [1:0]        r_state;
    logic [GIDX_W-1:0] r_gidx;
    logic [CW-1:0]     r_in;
    logic [CW-1:0]     r_out;
    logic [1:0]        r_mode;
    logic [LFSR_W-1:0] r_lfsr;
    logic [GW-1:0]     r_prev;

    logic [GW-1:0]     w_x;
    logic [GW-1:0]     w_rot;
    logic [GW-1:0]     w_y;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic              w_accept;
    logic              w_last;

    assign w_x         = r_in[int'(r_gidx)*GW +: GW];
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_accept    = (r_state == S_IDLE) && i_c_valid;
    assign w_last      = (r_gidx == GIDX_W'(NGROUP - 1));

    // A single-bit group has nothing to rotate, so it passes through unchanged.
    generate
        if (GW == 1) begin : g_rot_id
            assign w_rot = w_x;
        end else begin : g_rot
            assign w_rot = {w_x[GW-2:0], w_x[GW-1]};
        end
    endgenerate

    always_comb begin
        w_y = w_x;
        case (r_mode)
            M_BYPASS: w_y = w_x;
            M_ROTL:   w_y = w_rot;
            M_CHAIN:  w_y = w_x ^ r_prev;
            M_MASK:   w_y = w_x ^ r_lfsr[GW-1:0];
            default:  w_y = w_x;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_in    <= '0;
            r_out   <= '0;
            r_mode  <= M_BYPASS;
            r_prev  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in    <= i_c_in;
                        r_mode  <= i_mode;
                        r_out   <= '0;
                        r_prev  <= '0;
                        r_gidx  <= '0;
                        r_state <= S_PROC;
                    end
                end
                S_PROC: begin
                    r_out[int'(r_gidx)*GW +: GW] <= w_y;
                    r_prev <= w_y;
                    if (w_last) begin
                        r_gidx  <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_gidx <= r_gidx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_cbar_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The mask LFSR deliberately survives across transactions; only reset or a non-zero seed rewinds it.
    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_lfsr <= LFSR_INIT;
        end else if (r_state == S_IDLE) begin
            if (i_seed_load && (i_seed != '0)) begin
                r_lfsr <= i_seed;
            end
        end else if ((r_state == S_PROC) && (r_mode == M_MASK)) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_c_ready    = (r_state == S_IDLE);
    assign o_cbar_valid = (r_state == S_DONE);
    assign o_cbar_out   = r_out;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_challenge_obfuscator_param.sv
// Directed, table-driven bench for challenge_obfuscator_param (default parameters),
// plus hand-written sequences for seeding, backpressure and mid-transaction reset.
module tb_challenge_obfuscator_param;

    localparam int CW = 30;

    logic          clk;
    logic          clear;
    logic          cValid;
    logic          cReady;
    logic [CW-1:0] cIn;
    logic [1:0]    mode;
    logic          seedLoad;
    logic [15:0]   seed;
    logic          cbarValid;
    logic          cbarReady;
    logic [CW-1:0] cbarOut;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic [1:0]    mode;
        logic [CW-1:0] cin;
        logic [CW-1:0] expected;
    } vector_t;

    vector_t vecs[5];

    challenge_obfuscator_param dut (
        .i_clk        (clk),
        .i_clear      (clear),
        .i_c_valid    (cValid),
        .o_c_ready    (cReady),
        .i_c_in       (cIn),
        .i_mode       (mode),
        .i_seed_load  (seedLoad),
        .i_seed       (seed),
        .o_cbar_valid (cbarValid),
        .i_cbar_ready (cbarReady),
        .o_cbar_out   (cbarOut),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one transaction; returns the result and the number of clocks from accept to cbar_valid.
    task automatic applyStimulus(input logic [1:0] m, input logic [CW-1:0] cin,
                                 input logic ldSeed, input logic [15:0] sd,
                                 output logic [CW-1:0] result, output int latency,
                                 output logic readyLeaked);
        int waitCnt = 0;
        while (!cReady && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        cValid   = 1'b1;
        mode     = m;
        cIn      = cin;
        seedLoad = ldSeed;
        seed     = sd;
        tick();
        cValid   = 1'b0;
        seedLoad = 1'b0;
        mode     = ~m;
        cIn      = ~cin;
        latency  = 0;
        readyLeaked = 1'b0;
        while (!cbarValid && latency < 50) begin
            if (cReady) readyLeaked = 1'b1;
            tick();
            latency++;
        end
        result = cbarOut;
    endtask

    task automatic handshake();
        cbarReady = 1'b1;
        tick();
        cbarReady = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] res;
        logic [CW-1:0] held;
        int            lat;
        logic          leak;

        vecs[0] = '{"bypass",     2'b00, 30'h2AAA_5555, 30'h2AAA_5555};
        vecs[1] = '{"rotl_1",     2'b01, 30'h0000_0001, 30'h0000_0002};
        vecs[2] = '{"rotl_wrap",  2'b01, 30'h0000_0004, 30'h0000_0001};
        vecs[3] = '{"chain_7",    2'b10, 30'h0000_0007, 30'h3FFF_FFFF};
        vecs[4] = '{"rotl_multi", 2'b01, 30'h2492_4924, 30'h0924_9249};

        clear = 1'b0; cValid = 1'b0; cIn = '0; mode = '0;
        seedLoad = 1'b0; seed = '0; cbarReady = 1'b0;
        #12;
        checkOutput("rst_c_ready",    32'(cReady),    32'd1);
        checkOutput("rst_cbar_valid", 32'(cbarValid), 32'd0);
        checkOutput("rst_cbar_out",   32'(cbarOut),   32'd0);
        checkOutput("rst_busy",       32'(busy),      32'd0);
        clear = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].cin, 1'b0, 16'h0, res, lat, leak);
            checkOutput({vecs[i].name, "_out"},     32'(res),  32'(vecs[i].expected));
            checkOutput({vecs[i].name, "_latency"}, lat,       32'd10);
            checkOutput({vecs[i].name, "_c_ready"}, 32'(leak), 32'd0);
            checkOutput({vecs[i].name, "_busy"},    32'(busy), 32'd1);
            handshake();
            checkOutput({vecs[i].name, "_idle"},    32'(cReady), 32'd1);
        end

        // Seed loaded on the accept edge is used by that same transaction.
        applyStimulus(2'b11, 30'h0, 1'b1, 16'h0001, res, lat, leak);
        checkOutput("seed_mask_out", 32'(res), 32'h2000_0001);
        checkOutput("seed_latency",  lat,      32'd10);
        handshake();
        checkOutput("seed_lfsr_end", 32'(dut.r_lfsr), 32'h005A);
        seedLoad = 1'b1; seed = 16'h0000;
        tick();
        seedLoad = 1'b0;
        checkOutput("zero_seed_ignored", 32'(dut.r_lfsr), 32'h005A);
        applyStimulus(2'b11, 30'h0, 1'b0, 16'h0, res, lat, leak);
        checkOutput("mask_persist_out", 32'(res), 32'h0005_57AA);
        handshake();

        // Backpressure: result must hold while the consumer stalls.
        applyStimulus(2'b00, 30'h1555_5555, 1'b0, 16'h0, res, lat, leak);
        held = res;
        for (int i = 0; i < 5; i++) begin
            cValid = i[0];
            cIn    = 30'h3FFF_0000;
            tick();
            checkOutput("bp_valid",   32'(cbarValid), 32'd1);
            checkOutput("bp_out",     32'(cbarOut),   32'(held));
            checkOutput("bp_c_ready", 32'(cReady),    32'd0);
        end
        checkOutput("bp_result", 32'(held), 32'h1555_5555);
        cValid = 1'b1;
        handshake();
        checkOutput("bp_release_c_ready", 32'(cReady),    32'd1);
        checkOutput("bp_release_valid",   32'(cbarValid), 32'd0);
        checkOutput("bp_no_same_accept",  32'(busy),      32'd0);
        cValid = 1'b0;
        tick();

        // Reset in the middle of a masked transaction aborts it.
        cValid = 1'b1; mode = 2'b11; cIn = 30'h0123_4567;
        tick();
        cValid = 1'b0;
        repeat (4) tick();
        clear = 1'b0;
        #1;
        checkOutput("abort_c_ready",    32'(cReady),      32'd1);
        checkOutput("abort_cbar_valid", 32'(cbarValid),   32'd0);
        checkOutput("abort_cbar_out",   32'(cbarOut),     32'd0);
        checkOutput("abort_busy",       32'(busy),        32'd0);
        checkOutput("abort_lfsr",       32'(dut.r_lfsr),  32'hACE1);
        tick();
        clear = 1'b1;
        leak = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (cbarValid) leak = 1'b1;
        end
        checkOutput("abort_no_valid", 32'(leak), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
